// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// single sign-correction cycle before results are written to HI/LO.
module mult_div_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6   // 2**CNT_W must exceed DATA_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              is_div,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q;
  logic              is_div_q, is_signed_q, sign_rs_q, sign_rt_q, dz_q;
  logic [CNT_W-1:0]  cnt_q;
  // acc_hi_q/acc_lo_q: product halves for multiply, remainder/quotient for divide
  logic [DATA_W-1:0] acc_hi_q, acc_lo_q, opb_q;
  logic              busy_q, done_q, dbz_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  // Operand conditioning at accept time: magnitudes and sign flags
  logic              rs_neg, rt_neg, dz_in;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  assign rs_neg = is_signed & rs_data[DATA_W-1];
  assign rt_neg = is_signed & rt_data[DATA_W-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;
  assign dz_in  = is_div & (rt_data == '0);

  // One iteration step of either algorithm
  logic [DATA_W:0]   mul_sum, div_shift, div_trial;
  logic [DATA_W-1:0] step_hi_d, step_lo_d;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    step_hi_d = acc_hi_q;
    step_lo_d = acc_lo_q;
    mul_sum   = '0;
    div_shift = '0;
    div_trial = '0;
    if (is_div_q) begin
      // Remainder gains the next dividend bit; subtract when it fits.
      div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
      div_trial = div_shift - {1'b0, opb_q};
      if (!div_trial[DATA_W]) begin
        step_hi_d = div_trial[DATA_W-1:0];
        step_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
      end else begin
        step_hi_d = div_shift[DATA_W-1:0];
        step_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      // Conditional add with carry, then shift {carry, hi, lo} right.
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
      step_hi_d = mul_sum[DATA_W:1];
      step_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
    end
  end

  // Sign correction and divide-by-zero substitution for the HI/LO write
  logic              neg_res;
  logic [2*DATA_W-1:0] prod_d;
  logic [DATA_W-1:0] fix_hi_d, fix_lo_d;
  always_comb begin
    neg_res  = is_signed_q & (sign_rs_q ^ sign_rt_q);
    prod_d   = {acc_hi_q, acc_lo_q};
    fix_hi_d = acc_hi_q;
    fix_lo_d = acc_lo_q;
    if (dz_q) begin
      fix_hi_d = acc_lo_q;              // raw dividend was parked here
      fix_lo_d = '1;
    end else if (is_div_q) begin
      fix_lo_d = neg_res ? -acc_lo_q : acc_lo_q;
      fix_hi_d = (is_signed_q & sign_rs_q) ? -acc_hi_q : acc_hi_q;
    end else begin
      if (neg_res) prod_d = -prod_d;
      fix_hi_d = prod_d[2*DATA_W-1:DATA_W];
      fix_lo_d = prod_d[DATA_W-1:0];
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: every register is reset, so no stale operand or partial result can reach hi/lo after reset.
    if (!rst_b) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_rs_q   <= 1'b0;
      sign_rt_q   <= 1'b0;
      dz_q        <= 1'b0;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opb_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done_q <= 1'b0;
      if (abort) begin
        // Flush wins over everything, including a coincident start.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (start) begin
              is_div_q    <= is_div;
              is_signed_q <= is_signed;
              sign_rs_q   <= rs_neg;
              sign_rt_q   <= rt_neg;
              dz_q        <= dz_in;
              dbz_q       <= 1'b0;
              cnt_q       <= '0;
              acc_hi_q    <= '0;
              acc_lo_q    <= dz_in ? rs_data : (is_div ? rs_mag : rt_mag);
              opb_q       <= is_div ? rt_mag : rs_mag;
              busy_q      <= 1'b1;
              state_q     <= dz_in ? FIX : CALC;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          CALC: begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          FIX: begin
            hi_q    <= fix_hi_d;
            lo_q    <= fix_lo_d;
            dbz_q   <= dz_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
